// File: rtl/call_stack_if.sv
// Bus between the core controller and the return-address stack.
//
// Handshake: push, pop, flush and clr_err are single-cycle command strobes
// sampled on every rising clk edge. There is no valid/ready pair because the
// stack accepts a command on every cycle; illegal operations such as a push
// while full or a pop while empty are absorbed and recorded in the sticky
// overflow/underflow flags. The effect of a command is visible on the
// outputs in the cycle after the edge that sampled it, and all outputs are
// functions of registered state only.
interface call_stack_if #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] stack_in;
  logic [WIDTH-1:0] stack_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  // Controller side: issues commands, observes the top of stack and status.
  modport master (
    output push, pop, flush, clr_err, stack_in,
    input  stack_out, count, empty, full, overflow, underflow
  );

  // Stack side: consumes commands, presents the top of stack and status.
  modport slave (
    input  push, pop, flush, clr_err, stack_in,
    output stack_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Parametrised return-address stack for CALL/RETURN in the multi-cycle core.
// r_sp points at the next free slot and the top entry lives at r_sp-1.
// OVF_MODE=0 lets the pointer wrap like the classic PIC hardware stack:
// a push while full overwrites the oldest entry and a pop while empty
// rotates the pointer. OVF_MODE=1 rejects both cases and leaves state alone.
// Either way the offending attempt latches a sticky error flag.
module call_stack #(
  parameter int WIDTH    = 11,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0
) (
  input logic         clk,
  input logic         reset,
  call_stack_if.slave bus
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic          WRAP     = (OVF_MODE == 0);

  // Storage and bookkeeping state.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;

  // Decoded status and per-cycle operation qualifiers.
  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_top_idx;
  logic [PW-1:0] w_wr_idx;
  logic          w_replace;
  logic          w_push_op;
  logic          w_pop_op;
  logic          w_push_adv;
  logic          w_pop_mv;
  logic          w_cnt_inc;
  logic          w_cnt_dec;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic          w_mem_we;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  // Pointer arithmetic is modulo DEPTH because DEPTH is a power of two.
  assign w_top_idx = r_sp - PW'(1);

  // Command decode, flush first, then push&pop, then push, then pop.
  // A push&pop on an empty stack has no top to replace, so it degrades
  // to a plain push and must not raise underflow.
  assign w_replace = bus.push & bus.pop & ~w_empty & ~bus.flush;
  assign w_push_op = bus.push & ~(bus.pop & ~w_empty) & ~bus.flush;
  assign w_pop_op  = bus.pop & ~bus.push & ~bus.flush;

  // In wrap mode a full push still writes and advances, and an empty pop
  // still rotates the pointer; the count itself saturates at 0 and DEPTH.
  assign w_push_adv = w_push_op & (~w_full | WRAP);
  assign w_pop_mv   = w_pop_op & (~w_empty | WRAP);
  assign w_cnt_inc  = w_push_op & ~w_full;
  assign w_cnt_dec  = w_pop_op & ~w_empty;
  assign w_set_ovf  = w_push_op & w_full;
  assign w_set_unf  = w_pop_op & w_empty;

  // Replace rewrites the current top in place; a push fills the free slot.
  assign w_mem_we = w_push_adv | w_replace;
  assign w_wr_idx = w_replace ? w_top_idx : r_sp;

  // Entry storage: cleared on reset so stale data never leaks after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[w_wr_idx] <= bus.stack_in;
    end
  end

  // Stack pointer: flush rewinds to slot 0, push advances, pop retreats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else if (bus.flush) begin
      r_sp <= '0;
    end else if (w_push_adv) begin
      r_sp <= r_sp + PW'(1);
    end else if (w_pop_mv) begin
      r_sp <= r_sp - PW'(1);
    end
  end

  // Occupancy counter, bounded to 0..DEPTH in both overflow modes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~bus.clr_err) | w_set_ovf;
      r_unf <= (r_unf & ~bus.clr_err) | w_set_unf;
    end
  end

  // Top of stack feeds the PC mux; saturate mode shows zero when empty,
  // wrap mode keeps exposing whatever the rotated pointer addresses.
  assign bus.stack_out = (!WRAP && w_empty) ? '0 : r_mem[w_top_idx];
  assign bus.count     = r_cnt;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: one wrap-mode and one saturate-mode instance share
// clock and reset. Driver tasks issue one command per cycle and queue the
// hand-computed state expected after that edge; a monitor on the falling
// edge pops each expectation and compares it against the selected instance.
module tb_call_stack;

  localparam int W  = 11;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int VW = W + CW + 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  call_stack_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  call_stack_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int              sel;
    string           name;
    logic [VW-1:0]   vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected view: {stack_out, count, empty, full, overflow, underflow}.
  function automatic logic [VW-1:0] pack_exp(logic [W-1:0] o, int c, bit ov, bit un);
    logic [CW-1:0] cc;
    cc = CW'(c);
    return {o, cc, (c == 0), (c == D), ov, un};
  endfunction

  function automatic logic [VW-1:0] sample(int sel);
    if (sel == 0)
      return {if0.stack_out, if0.count, if0.empty, if0.full, if0.overflow, if0.underflow};
    return {if1.stack_out, if1.count, if1.empty, if1.full, if1.overflow, if1.underflow};
  endfunction

  task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual out=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected out=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
               name, act[VW-1 -: W], act[CW+3:4], act[3], act[2], act[1], act[0],
               exp[VW-1 -: W], exp[CW+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: outputs depend only on registered state, so the falling edge
  // sees the settled result of the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, sample(e.sel), e.vec);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(int sel, bit pu, bit po, bit fl, bit ce, logic [W-1:0] din);
    if0.push     = (sel == 0) && pu;
    if0.pop      = (sel == 0) && po;
    if0.flush    = (sel == 0) && fl;
    if0.clr_err  = (sel == 0) && ce;
    if0.stack_in = (sel == 0) ? din : '0;
    if1.push     = (sel == 1) && pu;
    if1.pop      = (sel == 1) && po;
    if1.flush    = (sel == 1) && fl;
    if1.clr_err  = (sel == 1) && ce;
    if1.stack_in = (sel == 1) ? din : '0;
  endtask

  task automatic op(int sel, bit pu, bit po, bit fl, bit ce, logic [W-1:0] din,
                    logic [W-1:0] e_out, int e_cnt, bit e_ovf, bit e_unf, string name);
    exp_t e;
    @(negedge clk);
    drive(sel, pu, po, fl, ce, din);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    e.sel  = sel;
    e.name = name;
    e.vec  = pack_exp(e_out, e_cnt, e_ovf, e_unf);
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wrap", sample(0), pack_exp('0, 0, 1'b0, 1'b0));
    check("reset_sat",  sample(1), pack_exp('0, 0, 1'b0, 1'b0));
    reset = 1'b1;

    op(0, 0, 0, 0, 0, '0, '0, 0, 0, 0, "idle_wrap");
    op(1, 0, 0, 0, 0, '0, '0, 0, 0, 0, "idle_sat");

    // Basic LIFO order; final pop on wrap shows reset-cleared mem[7].
    op(0, 1, 0, 0, 0, 11'h001, 11'h001, 1, 0, 0, "basic_push1");
    op(0, 1, 0, 0, 0, 11'h002, 11'h002, 2, 0, 0, "basic_push2");
    op(0, 1, 0, 0, 0, 11'h003, 11'h003, 3, 0, 0, "basic_push3");
    op(0, 0, 1, 0, 0, '0, 11'h002, 2, 0, 0, "basic_pop1");
    op(0, 0, 1, 0, 0, '0, 11'h001, 1, 0, 0, "basic_pop2");
    op(0, 0, 1, 0, 0, '0, 11'h000, 0, 0, 0, "basic_pop3");

    // Wrap mode: ninth push overwrites 0x100; pops return 0x108..0x101.
    for (int i = 0; i < 9; i++)
      op(0, 1, 0, 0, 0, W'(256 + i), W'(256 + i), (i < 8) ? i + 1 : 8, (i == 8), 0, "wrap_push");
    for (int k = 1; k <= 8; k++)
      op(0, 0, 1, 0, 0, '0, (k < 8) ? W'(264 - k) : W'(264), 8 - k, 1, 0, "wrap_pop");
    op(0, 0, 1, 0, 0, '0, 11'h107, 0, 1, 1, "wrap_pop_empty");
    op(0, 0, 0, 0, 1, '0, 11'h107, 0, 0, 0, "wrap_clr_err");
    op(0, 0, 0, 1, 0, '0, 11'h107, 0, 0, 0, "wrap_flush");

    // Saturate mode: ninth push rejected; empty pop leaves pointer alone.
    for (int i = 0; i < 9; i++)
      op(1, 1, 0, 0, 0, W'(256 + i), (i < 8) ? W'(256 + i) : W'(263), (i < 8) ? i + 1 : 8, (i == 8), 0, "sat_push");
    for (int k = 1; k <= 8; k++)
      op(1, 0, 1, 0, 0, '0, (k < 8) ? W'(263 - k) : W'(0), 8 - k, 1, 0, "sat_pop");
    op(1, 0, 1, 0, 0, '0, 11'h000, 0, 1, 1, "sat_pop_empty");
    op(1, 1, 0, 0, 0, 11'h0AB, 11'h0AB, 1, 1, 1, "sat_push_after_empty_pop");
    op(1, 0, 0, 0, 1, '0, 11'h0AB, 1, 0, 0, "sat_clr_err");
    op(1, 0, 1, 0, 0, '0, 11'h000, 0, 0, 0, "sat_pop_last");

    // Replace and push&pop on empty.
    op(1, 1, 0, 0, 0, 11'h055, 11'h055, 1, 0, 0, "repl_push");
    op(1, 1, 1, 0, 0, 11'h0AA, 11'h0AA, 1, 0, 0, "repl_pushpop");
    op(1, 0, 1, 0, 0, '0, 11'h000, 0, 0, 0, "repl_pop");
    op(1, 1, 1, 0, 0, 11'h011, 11'h011, 1, 0, 0, "pushpop_empty");
    op(1, 0, 1, 0, 0, '0, 11'h000, 0, 0, 0, "pushpop_empty_pop");

    // Flush priority over push; clr_err loses to a same-cycle underflow.
    for (int i = 0; i < 5; i++)
      op(0, 1, 0, 0, 0, W'(512 + i), W'(512 + i), i + 1, 0, 0, "flush_fill");
    op(0, 1, 0, 1, 0, 11'h3AA, 11'h107, 0, 0, 0, "flush_with_push");
    op(0, 0, 1, 0, 1, '0, 11'h106, 0, 0, 1, "clr_vs_underflow");
    op(0, 0, 0, 0, 1, '0, 11'h106, 0, 0, 0, "clr_after_underflow");
    op(0, 0, 0, 1, 0, '0, 11'h107, 0, 0, 0, "flush_empty");

    // Asynchronous reset between edges.
    op(0, 1, 0, 0, 0, 11'h3FF, 11'h3FF, 1, 0, 0, "pre_reset_push");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_wrap", sample(0), pack_exp('0, 0, 1'b0, 1'b0));
    check("async_reset_sat",  sample(1), pack_exp('0, 0, 1'b0, 1'b0));
    #1;
    reset = 1'b1;
    op(0, 0, 0, 0, 0, '0, '0, 0, 0, 0, "post_reset_wrap");
    op(1, 0, 0, 0, 0, '0, '0, 0, 0, 0, "post_reset_sat");

    // Drain the scoreboard with a bounded wait.
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
Parametrised return-address stack for the multi-cycle core. It replaces the fixed 8-level, 11-bit stack used by CALL/RETURN. It adds configurable width and depth, a selectable overflow policy (PIC-style circular wrap or saturate/reject), a simultaneous push+pop replace operation, flush, occupancy count and sticky overflow/underflow error flags. The controller drives push in T4 of CALL and pop in T4 of RETURN. stack_out feeds the PC next-address mux.

Parameters:
WIDTH, 11, bits per entry (PC width)
DEPTH, 8, number of entries; power of 2, >= 2
OVF_MODE, 0, 0 = circular wrap (overwrite oldest / pointer wraps), 1 = saturate (reject op on full/empty)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
push  input  1  write stack_in as new top this cycle
pop  input  1  discard top this cycle
flush  input  1  empty the stack (synchronous)
clr_err  input  1  clear sticky error flags (synchronous)
stack_in  input  WIDTH  value to push (return address)
stack_out  output  WIDTH  current top entry, combinational from state
count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- State: mem[DEPTH] of WIDTH; sp ($clog2(DEPTH) bits) = index of next free slot; cnt (0..DEPTH); two sticky flags.
- Reset (reset=0, async): sp=0, cnt=0, all mem entries=0, overflow=0, underflow=0. Outputs: stack_out=0, count=0, empty=1, full=0.
- stack_out = mem[(sp-1) mod DEPTH] in both modes; when OVF_MODE=1 and empty, stack_out=0.
- All updates occur on the rising clk edge. Priority: flush > push&pop > push > pop.
- flush: sp<=0, cnt<=0; mem contents untouched; push/pop ignored that cycle; flags unchanged (except clr_err).
- push only, not full: mem[sp]<=stack_in, sp<=sp+1 mod DEPTH, cnt<=cnt+1.
- push only, full:
  - OVF_MODE=0: write and advance sp (overwrites oldest entry); cnt stays DEPTH; overflow<=1.
  - OVF_MODE=1: no state change; overflow<=1.
- pop only, not empty: sp<=sp-1 mod DEPTH, cnt<=cnt-1; mem unchanged.
- pop only, empty:
  - OVF_MODE=0: sp<=sp-1 mod DEPTH (circular), cnt stays 0; underflow<=1.
  - OVF_MODE=1: no state change; underflow<=1.
- push&pop, cnt>0: replace top, i.e. mem[sp-1]<=stack_in; sp and cnt unchanged; no flags.
- push&pop, cnt==0: behaves as push only; underflow not set.
- clr_err: clears both flags. If an error event occurs in the same cycle, set wins.
- Latency: a push is visible on stack_out the cycle after the edge. A pop exposes the next entry the cycle after the edge.
- count/empty/full derive combinationally from cnt; no glitch-sensitive use is permitted outside clk domain.
- Reset asserted mid-operation aborts any pending update; state returns to reset values immediately.

Test Plan:
- Reset, then push 0x001, 0x002, 0x003 -> stack_out 0x003, count 3. Pop x3 -> stack_out 0x002, 0x001, then empty=1, underflow=0.
- DEPTH=8, OVF_MODE=0: push 0x100..0x108 (9 pushes) -> full=1, overflow=1, stack_out 0x108. Pop x8 returns 0x108..0x101; 0x100 is lost.
- DEPTH=8, OVF_MODE=1: 9 pushes 0x100..0x108 -> overflow=1, stack_out 0x107. Pop on empty -> underflow=1, sp unchanged, stack_out=0.
- Push 0x055, then push&pop with 0x0AA -> count 1, stack_out 0x0AA. push&pop on empty with 0x011 -> count 1, stack_out 0x011, underflow=0.
- count=5, assert flush with push=1 -> count 0, empty=1. clr_err in same cycle as pop-on-empty -> underflow=1.
- Push 0x3FF, assert reset low asynchronously between clock edges -> count 0 and stack_out 0 before the next edge. Flags stay 0 after release.
